// File: rtl/sram_stream_fifo.sv
// Stream FIFO backed by an external 1W/1R SRAM. A 2-entry output buffer is
// prefetched from the SRAM so the one-cycle read latency is hidden from the sink.
`timescale 1ns/1ps
module sram_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    // upstream stream
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    // downstream stream
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    // SRAM port 0 (write only)
    output logic                  csb0,
    output logic                  web0,
    output logic [3:0]            wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    // SRAM port 1 (read only)
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    // status
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  empty,
    output logic                  full
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_sram_cnt;
    logic                  r_inflight;
    logic [1:0]            r_buf_cnt;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_rst_done;

    logic                  w_wr_fire;
    logic                  w_pop;
    logic                  w_rd_issue;
    logic [2:0]            w_occ;
    logic [1:0]            w_buf_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_buf_nxt [2];

    // r_rst_done holds off in_ready until the first edge after reset release.
    assign in_ready  = r_rst_done && (r_sram_cnt != DEPTH) && !flush;
    assign w_wr_fire = in_valid && in_ready;

    assign out_valid = (r_buf_cnt != 2'd0);
    assign out_data  = r_buf[0];
    assign w_pop     = out_valid && out_ready;

    // Buffer slots that will be taken once everything already committed lands.
    assign w_occ      = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_issue = (r_sram_cnt != '0) && (w_occ < 3'd2) && !flush;

    assign csb0   = !w_wr_fire;
    assign web0   = !w_wr_fire;
    assign wmask0 = w_wr_fire ? 4'hF : 4'h0;
    assign addr0  = w_wr_fire ? r_wr_ptr : '0;
    assign din0   = w_wr_fire ? in_data : '0;

    assign csb1  = !w_rd_issue;
    assign addr1 = w_rd_issue ? r_rd_ptr : '0;

    assign level = {1'b0, r_sram_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, r_inflight}
                 + {{ADDR_WIDTH{1'b0}}, r_buf_cnt};
    assign empty = (level == '0);
    assign full  = (r_sram_cnt == DEPTH);

    // Output buffer: entry 0 is always the oldest word. A capture lands in the
    // first free slot after any pop has shifted entry 1 down.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_buf_nxt     = r_buf;
        w_buf_cnt_nxt = r_buf_cnt;
        case ({r_inflight, w_pop})
            2'b01: begin
                w_buf_nxt[0]  = r_buf[1];
                w_buf_cnt_nxt = r_buf_cnt - 2'd1;
            end
            2'b10: begin
                w_buf_nxt[r_buf_cnt[0]] = dout1;
                w_buf_cnt_nxt           = r_buf_cnt + 2'd1;
            end
            2'b11: begin
                if (r_buf_cnt[1]) begin
                    w_buf_nxt[0] = r_buf[1];
                    w_buf_nxt[1] = dout1;
                end else begin
                    w_buf_nxt[0] = dout1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_sram_cnt <= '0;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            // NOTE: the two buffer words are reset because they are flops; the SRAM array itself never is.
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_rst_done <= 1'b0;
        end else if (flush) begin
            // Clearing r_inflight drops a read whose data returns next cycle.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_sram_cnt <= '0;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_rst_done <= 1'b1;
        end else begin
            r_rst_done <= 1'b1;
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_fire, w_rd_issue})
                2'b10:   r_sram_cnt <= r_sram_cnt + 1'b1;
                2'b01:   r_sram_cnt <= r_sram_cnt - 1'b1;
                default: r_sram_cnt <= r_sram_cnt;
            endcase
            r_inflight <= w_rd_issue;
            r_buf_cnt  <= w_buf_cnt_nxt;
            r_buf      <= w_buf_nxt;
        end
    end

endmodule
